// File: rtl/vga_sprite_compositor.sv
// ---------------------------------------------------------------------------
// vga_sprite_compositor
//
// Per-pixel sprite front/back end wrapped around the shared sprite RAM.
//
// Front end: checks the current VGA pixel against NUM_ALIENS alien boxes and
// one player box. It then drives one registered read address per sprite RAM
// port.
//
// Back end: takes the RAM's registered read data and applies transparency
// and priority (player first, then alien 0 upward). It emits one colour index
// per pixel, three cycles after that pixel was presented.
//
// It also accumulates player/alien overlaps over a frame. The result is
// handed to game logic at the next frame_start.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   pixel_x/pixel_y      current pixel position
//   pixel_valid          pixel lies in the active video area
//   frame_start          one-cycle pulse at the start of each frame
//   alien_x/y_flat       alien top-left positions, alien i at [i*W +: W]
//   alien_alive          per-alien enable
//   player_x/player_y    player top-left position
//   ram_wr_active        sprite RAM is being written, so reads are stale
//   addr_alien_flat      registered alien read addresses
//   addr_player          registered player read address
//   alien_data_flat      RAM read data for the alien ports
//   player_data          RAM read data for the player port
//   pixel_color          composited colour index
//   color_valid          pixel_color belongs to an active pixel
//   collision_report     per-alien overlap bits for the previous frame
//   collision_strobe     one-cycle pulse when collision_report updates
// ---------------------------------------------------------------------------
module vga_sprite_compositor #(
   parameter int NUM_ALIENS    = 10,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10,
   parameter int X_WIDTH       = 10,
   parameter int Y_WIDTH       = 9,
   parameter int SPRITE_W      = 16,
   parameter int SPRITE_H      = 16,
   parameter int ALIEN_BASE    = 0,
   parameter int PLAYER_BASE   = 256,
   parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 8'h00,
   parameter logic [DATA_WIDTH-1:0] BG_COLOR    = 8'h00
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [X_WIDTH-1:0]                pixel_x,
   input  logic [Y_WIDTH-1:0]                pixel_y,
   input  logic                              pixel_valid,
   input  logic                              frame_start,
   input  logic [NUM_ALIENS*X_WIDTH-1:0]     alien_x_flat,
   input  logic [NUM_ALIENS*Y_WIDTH-1:0]     alien_y_flat,
   input  logic [NUM_ALIENS-1:0]             alien_alive,
   input  logic [X_WIDTH-1:0]                player_x,
   input  logic [Y_WIDTH-1:0]                player_y,
   input  logic                              ram_wr_active,
   output logic [NUM_ALIENS*ADDRESS_WIDTH-1:0] addr_alien_flat,
   output logic [ADDRESS_WIDTH-1:0]          addr_player,
   input  logic [NUM_ALIENS*DATA_WIDTH-1:0]  alien_data_flat,
   input  logic [DATA_WIDTH-1:0]             player_data,
   output logic [DATA_WIDTH-1:0]             pixel_color,
   output logic                              color_valid,
   output logic [NUM_ALIENS-1:0]             collision_report,
   output logic                              collision_strobe
);

   // Sprite sizes are powers of two, so the in-sprite offset is just the
   // low bits of the coordinate difference.
   localparam int SPR_XB = $clog2(SPRITE_W);
   localparam int SPR_YB = $clog2(SPRITE_H);

   localparam logic [ADDRESS_WIDTH-1:0] ALIEN_BASE_A  = ADDRESS_WIDTH'(ALIEN_BASE);
   localparam logic [ADDRESS_WIDTH-1:0] PLAYER_BASE_A = ADDRESS_WIDTH'(PLAYER_BASE);

   // Box extents are one bit wider than the coordinates, so a sprite that
   // hangs off the right or bottom edge never wraps round to column/row 0.
   localparam logic [X_WIDTH:0] SPR_W_EXT = (X_WIDTH+1)'(SPRITE_W);
   localparam logic [Y_WIDTH:0] SPR_H_EXT = (Y_WIDTH+1)'(SPRITE_H);

   // Shadow copies of sprite positions, taken once per frame.
   logic [NUM_ALIENS-1:0][X_WIDTH-1:0] r_alienX;
   logic [NUM_ALIENS-1:0][Y_WIDTH-1:0] r_alienY;
   logic [NUM_ALIENS-1:0]              r_alive;
   logic [X_WIDTH-1:0]                 r_playerX;
   logic [Y_WIDTH-1:0]                 r_playerY;

   // Stage 1 results (visible at T+1).
   logic [NUM_ALIENS-1:0][ADDRESS_WIDTH-1:0] r_addrAlien;
   logic [ADDRESS_WIDTH-1:0]                 r_addrPlayer;
   logic [NUM_ALIENS-1:0]                    r_alienIn1;
   logic                                     r_playerIn1;
   logic                                     r_valid1;

   // Stage 2 flags, aligned with the RAM data (visible at T+2).
   logic [NUM_ALIENS-1:0] r_alienIn2;
   logic                  r_playerIn2;
   logic                  r_valid2;
   logic                  r_stale2;

   // Stage 3 outputs and collision bookkeeping.
   logic [DATA_WIDTH-1:0] r_pixelColor;
   logic                  r_colorValid;
   logic [NUM_ALIENS-1:0] r_acc;
   logic [NUM_ALIENS-1:0] r_report;
   logic                  r_strobe;

   // Combinational stage 1 and stage 3 signals.
   logic [NUM_ALIENS-1:0]                    w_alienIn;
   logic [NUM_ALIENS-1:0][ADDRESS_WIDTH-1:0] w_alienAddr;
   logic                                     w_playerIn;
   logic [ADDRESS_WIDTH-1:0]                 w_playerAddr;
   logic [NUM_ALIENS-1:0][DATA_WIDTH-1:0]    w_alienData;
   logic [NUM_ALIENS-1:0]                    w_alienOpaque;
   logic                                     w_playerOpaque;
   logic [NUM_ALIENS-1:0]                    w_hits;
   logic [DATA_WIDTH-1:0]                    w_colorNext;

   // Latch every position at frame_start. The comparators only look at the
   // shadows, so game logic can move sprites at any time without tearing
   // the frame currently on screen.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_alienX  <= '0;
         r_alienY  <= '0;
         r_alive   <= '0;
         r_playerX <= '0;
         r_playerY <= '0;
      end else if (frame_start) begin
         r_alienX  <= alien_x_flat;
         r_alienY  <= alien_y_flat;
         r_alive   <= alien_alive;
         r_playerX <= player_x;
         r_playerY <= player_y;
      end
   end

   // Per-alien box test and read-address generation. An out-of-box alien
   // parks its port on the image base, so the RAM address stays quiet.
   for (genvar g = 0; g < NUM_ALIENS; g++) begin : g_alien
      logic [X_WIDTH:0] w_xEnd;
      logic [Y_WIDTH:0] w_yEnd;
      logic [SPR_XB-1:0] w_dx;
      logic [SPR_YB-1:0] w_dy;

      assign w_xEnd = {1'b0, r_alienX[g]} + SPR_W_EXT;
      assign w_yEnd = {1'b0, r_alienY[g]} + SPR_H_EXT;
      assign w_dx   = pixel_x[SPR_XB-1:0] - r_alienX[g][SPR_XB-1:0];
      assign w_dy   = pixel_y[SPR_YB-1:0] - r_alienY[g][SPR_YB-1:0];

      assign w_alienIn[g] = pixel_valid && r_alive[g]
                            && (pixel_x >= r_alienX[g]) && ({1'b0, pixel_x} < w_xEnd)
                            && (pixel_y >= r_alienY[g]) && ({1'b0, pixel_y} < w_yEnd);

      assign w_alienAddr[g] = w_alienIn[g]
                              ? ALIEN_BASE_A + ADDRESS_WIDTH'({w_dy, w_dx})
                              : ALIEN_BASE_A;
   end

   // The player uses the same box test, but it is always alive.
   logic [X_WIDTH:0]  w_playerXEnd;
   logic [Y_WIDTH:0]  w_playerYEnd;
   logic [SPR_XB-1:0] w_playerDx;
   logic [SPR_YB-1:0] w_playerDy;

   assign w_playerXEnd = {1'b0, r_playerX} + SPR_W_EXT;
   assign w_playerYEnd = {1'b0, r_playerY} + SPR_H_EXT;
   assign w_playerDx   = pixel_x[SPR_XB-1:0] - r_playerX[SPR_XB-1:0];
   assign w_playerDy   = pixel_y[SPR_YB-1:0] - r_playerY[SPR_YB-1:0];

   assign w_playerIn = pixel_valid
                       && (pixel_x >= r_playerX) && ({1'b0, pixel_x} < w_playerXEnd)
                       && (pixel_y >= r_playerY) && ({1'b0, pixel_y} < w_playerYEnd);

   assign w_playerAddr = w_playerIn
                         ? PLAYER_BASE_A + ADDRESS_WIDTH'({w_playerDy, w_playerDx})
                         : PLAYER_BASE_A;

   // Stage 1 register: the addresses go straight to the RAM. The in-box
   // flags start their trip down the pipeline alongside them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addrAlien  <= {NUM_ALIENS{ALIEN_BASE_A}};
         r_addrPlayer <= PLAYER_BASE_A;
         r_alienIn1   <= '0;
         r_playerIn1  <= 1'b0;
         r_valid1     <= 1'b0;
      end else begin
         r_addrAlien  <= w_alienAddr;
         r_addrPlayer <= w_playerAddr;
         r_alienIn1   <= w_alienIn;
         r_playerIn1  <= w_playerIn;
         r_valid1     <= pixel_valid;
      end
   end

   // Stage 2 register: delay the flags by one more cycle so they line up
   // with the RAM's registered read data. The RAM samples the address in
   // the same cycle as ram_wr_active is captured here, so that cycle
   // decides whether this pixel's data is stale.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_alienIn2  <= '0;
         r_playerIn2 <= 1'b0;
         r_valid2    <= 1'b0;
         r_stale2    <= 1'b0;
      end else begin
         r_alienIn2  <= r_alienIn1;
         r_playerIn2 <= r_playerIn1;
         r_valid2    <= r_valid1;
         r_stale2    <= ram_wr_active;
      end
   end

   assign w_alienData    = alien_data_flat;
   assign w_alienOpaque  = r_alienIn2 & {NUM_ALIENS{!r_stale2}}
                           & ~transparentMask(w_alienData);
   assign w_playerOpaque = r_playerIn2 && !r_stale2 && (player_data != TRANSPARENT);
   assign w_hits         = w_alienOpaque & {NUM_ALIENS{w_playerOpaque}};

   // One bit per alien: its read data is the see-through colour.
   function automatic logic [NUM_ALIENS-1:0] transparentMask(
      input logic [NUM_ALIENS-1:0][DATA_WIDTH-1:0] data
   );
      logic [NUM_ALIENS-1:0] mask;
      mask = '0;
      for (int i = 0; i < NUM_ALIENS; i++) begin
         mask[i] = (data[i] == TRANSPARENT);
      end
      return mask;
   endfunction

   // Priority mux. The aliens are scanned from the highest index down, so
   // the lowest opaque index is written last and wins. The player overrides
   // every alien.
   always_comb begin
      w_colorNext = BG_COLOR;
      for (int i = NUM_ALIENS-1; i >= 0; i--) begin
         if (w_alienOpaque[i]) begin
            w_colorNext = w_alienData[i];
         end
      end
      if (w_playerOpaque) begin
         w_colorNext = player_data;
      end
   end

   // Stage 3 register: the composited colour for the pixel presented three
   // cycles earlier.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pixelColor <= BG_COLOR;
         r_colorValid <= 1'b0;
      end else begin
         r_pixelColor <= w_colorNext;
         r_colorValid <= r_valid2;
      end
   end

   // Collision accumulator. At frame_start the finished frame's bits move
   // into the report. A hit landing in that same cycle seeds the fresh
   // accumulator rather than being lost.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc    <= '0;
         r_report <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= frame_start;
         if (frame_start) begin
            r_report <= r_acc;
            r_acc    <= w_hits;
         end else begin
            r_acc    <= r_acc | w_hits;
         end
      end
   end

   assign addr_alien_flat  = r_addrAlien;
   assign addr_player      = r_addrPlayer;
   assign pixel_color      = r_pixelColor;
   assign color_valid      = r_colorValid;
   assign collision_report = r_report;
   assign collision_strobe = r_strobe;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_compositor
//
// Directed bench for vga_sprite_compositor. A small registered-read RAM
// model feeds the data ports. Each pixel is presented for one cycle and the
// results are collected at T+1 (addresses), T+2, T+3 (colour) and T+4.
// Expected values are hand-computed from the sprite positions and the RAM
// contents loaded below.
// ---------------------------------------------------------------------------
module tb_vga_sprite_compositor;

   localparam int NA = 10;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int XW = 10;
   localparam int YW = 9;

   logic               clk;
   logic               resetn;
   logic [XW-1:0]      pixelX;
   logic [YW-1:0]      pixelY;
   logic               pixelValid;
   logic               frameStart;
   logic [NA*XW-1:0]   alienXFlat;
   logic [NA*YW-1:0]   alienYFlat;
   logic [NA-1:0]      alienAlive;
   logic [XW-1:0]      playerX;
   logic [YW-1:0]      playerY;
   logic               ramWrActive;
   logic [NA*AW-1:0]   addrAlienFlat;
   logic [AW-1:0]      addrPlayer;
   logic [NA*DW-1:0]   alienDataFlat;
   logic [DW-1:0]      playerData;
   logic [DW-1:0]      pixelColor;
   logic               colorValid;
   logic [NA-1:0]      collisionReport;
   logic               collisionStrobe;

   logic [DW-1:0]      mem [0:1023];

   int compared;
   int mismatched;

   // Values captured by applyStimulus / pulseFrame.
   logic [AW-1:0]    obsAddrPlayer;
   logic [NA*AW-1:0] obsAddrAlien;
   logic             obsValidEarly;
   logic [DW-1:0]    obsColor;
   logic             obsValid;
   logic             obsValidAfter;
   logic             obsStrobe;
   logic [NA-1:0]    obsReport;
   logic             obsStrobeAfter;

   vga_sprite_compositor dut (
      .clk              (clk),
      .resetn           (resetn),
      .pixel_x          (pixelX),
      .pixel_y          (pixelY),
      .pixel_valid      (pixelValid),
      .frame_start      (frameStart),
      .alien_x_flat     (alienXFlat),
      .alien_y_flat     (alienYFlat),
      .alien_alive      (alienAlive),
      .player_x         (playerX),
      .player_y         (playerY),
      .ram_wr_active    (ramWrActive),
      .addr_alien_flat  (addrAlienFlat),
      .addr_player      (addrPlayer),
      .alien_data_flat  (alienDataFlat),
      .player_data      (playerData),
      .pixel_color      (pixelColor),
      .color_valid      (colorValid),
      .collision_report (collisionReport),
      .collision_strobe (collisionStrobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read sprite RAM: data appears the cycle after the address.
   always @(posedge clk) begin
      playerData <= mem[addrPlayer];
      for (int i = 0; i < NA; i++) begin
         alienDataFlat[i*DW +: DW] <= mem[addrAlienFlat[i*AW +: AW]];
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one pixel at the current negedge. wrAt picks which cycle
   // (0 = T, 1 = T+1, 2 = T+2, anything else = never) has ram_wr_active high.
   task automatic applyStimulus(input int x, input int y, input int wrAt);
      pixelX      = XW'(x);
      pixelY      = YW'(y);
      pixelValid  = 1'b1;
      ramWrActive = (wrAt == 0);
      @(negedge clk);
      pixelValid    = 1'b0;
      ramWrActive   = (wrAt == 1);
      obsAddrPlayer = addrPlayer;
      obsAddrAlien  = addrAlienFlat;
      @(negedge clk);
      ramWrActive   = (wrAt == 2);
      obsValidEarly = colorValid;
      @(negedge clk);
      ramWrActive = 1'b0;
      obsColor    = pixelColor;
      obsValid    = colorValid;
      @(negedge clk);
      obsValidAfter = colorValid;
   endtask

   task automatic pulseFrame();
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      obsStrobe  = collisionStrobe;
      obsReport  = collisionReport;
      @(negedge clk);
      obsStrobeAfter = collisionStrobe;
   endtask

   function automatic logic [AW-1:0] alienAddr(input int idx);
      logic [NA*AW-1:0] flat;
      flat = obsAddrAlien;
      return flat[idx*AW +: AW];
   endfunction

   initial begin
      compared    = 0;
      mismatched  = 0;
      resetn      = 1'b0;
      pixelX      = '0;
      pixelY      = '0;
      pixelValid  = 1'b0;
      frameStart  = 1'b0;
      alienXFlat  = '0;
      alienYFlat  = '0;
      alienAlive  = '0;
      playerX     = '0;
      playerY     = '0;
      ramWrActive = 1'b0;

      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[0]   = 8'h77;
      mem[34]  = 8'h88;
      mem[80]  = 8'h55;
      mem[89]  = 8'h5A;
      mem[95]  = 8'h5B;
      mem[100] = 8'h44;
      mem[256] = 8'h66;
      mem[339] = 8'h1C;
      mem[356] = 8'h33;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_addr_player", 32'(addrPlayer), 32'd256);
      checkOutput("rst_addr_alien", 32'(addrAlienFlat[31:0]), 32'd0);
      checkOutput("rst_color", 32'(pixelColor), 32'h00);
      checkOutput("rst_valid", 32'(colorValid), 32'd0);
      checkOutput("rst_report", 32'(collisionReport), 32'd0);
      checkOutput("rst_strobe", 32'(collisionStrobe), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Frame A positions: alien0 at (1015,50), alien2 at (100,200),
      // alien4 at (10,10) but dead, player at (100,200).
      alienXFlat[0*XW +: XW] = 10'd1015;
      alienYFlat[0*YW +: YW] = 9'd50;
      alienXFlat[2*XW +: XW] = 10'd100;
      alienYFlat[2*YW +: YW] = 9'd200;
      alienXFlat[4*XW +: XW] = 10'd10;
      alienYFlat[4*YW +: YW] = 9'd10;
      alienAlive = 10'b0000000101;
      playerX    = 10'd100;
      playerY    = 9'd200;
      pulseFrame();
      checkOutput("frameA_strobe", 32'(obsStrobe), 32'd1);
      checkOutput("frameA_report", 32'(obsReport), 32'd0);
      checkOutput("frameA_strobe_off", 32'(obsStrobeAfter), 32'd0);

      // Player pixel: row 5, col 3.
      applyStimulus(103, 205, -1);
      $display("[TB] player pixel (103,205)");
      checkOutput("p1_addr_player", 32'(obsAddrPlayer), 32'd339);
      checkOutput("p1_addr_alien2", 32'(alienAddr(2)), 32'd83);
      checkOutput("p1_valid_t2", 32'(obsValidEarly), 32'd0);
      checkOutput("p1_color", 32'(obsColor), 32'h1C);
      checkOutput("p1_valid", 32'(obsValid), 32'd1);
      checkOutput("p1_valid_t4", 32'(obsValidAfter), 32'd0);

      // Player over alien 2, both opaque: player wins, alien 2 collides.
      applyStimulus(104, 206, -1);
      checkOutput("p2_addr_alien2", 32'(alienAddr(2)), 32'd100);
      checkOutput("p2_color", 32'(obsColor), 32'h33);

      // Alien 0 hanging off the right edge.
      applyStimulus(1014, 55, -1);
      checkOutput("p3_left_addr", 32'(alienAddr(0)), 32'd0);
      checkOutput("p3_left_color", 32'(obsColor), 32'h00);
      applyStimulus(1015, 55, -1);
      checkOutput("p3_in_addr", 32'(alienAddr(0)), 32'd80);
      checkOutput("p3_in_color", 32'(obsColor), 32'h55);
      applyStimulus(0, 55, -1);
      checkOutput("p3_x0_addr", 32'(alienAddr(0)), 32'd0);
      checkOutput("p3_x0_color", 32'(obsColor), 32'h00);
      applyStimulus(6, 55, -1);
      checkOutput("p3_x6_addr", 32'(alienAddr(0)), 32'd0);
      checkOutput("p3_x6_color", 32'(obsColor), 32'h00);

      // Dead alien 4 over opaque data.
      applyStimulus(12, 12, -1);
      checkOutput("p4_addr_alien4", 32'(alienAddr(4)), 32'd0);
      checkOutput("p4_color", 32'(obsColor), 32'h00);

      // Stale window: only a write at T+1 hides the pixel.
      applyStimulus(103, 205, 1);
      checkOutput("p5_wr_t1_color", 32'(obsColor), 32'h00);
      checkOutput("p5_wr_t1_valid", 32'(obsValid), 32'd1);
      applyStimulus(103, 205, 0);
      checkOutput("p5_wr_t0_color", 32'(obsColor), 32'h1C);
      applyStimulus(103, 205, 2);
      checkOutput("p5_wr_t2_color", 32'(obsColor), 32'h1C);

      // Mid-frame move is ignored until the next frame_start.
      playerX = 10'd300;
      applyStimulus(103, 205, -1);
      checkOutput("p6_nomove_color", 32'(obsColor), 32'h1C);
      pulseFrame();
      checkOutput("frameB_strobe", 32'(obsStrobe), 32'd1);
      checkOutput("frameB_report", 32'(obsReport), 32'b0000000100);
      checkOutput("frameB_strobe_off", 32'(obsStrobeAfter), 32'd0);
      applyStimulus(103, 205, -1);
      checkOutput("p6_old_spot_color", 32'(obsColor), 32'h00);
      applyStimulus(303, 205, -1);
      checkOutput("p6_new_addr", 32'(obsAddrPlayer), 32'd339);
      checkOutput("p6_new_color", 32'(obsColor), 32'h1C);

      // Reset mid-stream with a pixel in flight.
      pixelX     = 10'd303;
      pixelY     = 9'd205;
      pixelValid = 1'b1;
      @(negedge clk);
      pixelValid = 1'b0;
      resetn     = 1'b0;
      #1;
      checkOutput("mr_color", 32'(pixelColor), 32'h00);
      checkOutput("mr_valid", 32'(colorValid), 32'd0);
      checkOutput("mr_report", 32'(collisionReport), 32'd0);
      checkOutput("mr_addr_player", 32'(addrPlayer), 32'd256);
      @(negedge clk);
      @(negedge clk);
      checkOutput("mr_valid_held", 32'(colorValid), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("mr_valid_release", 32'(colorValid), 32'd0);

      // Shadows are back at (0,0): the player covers the origin.
      applyStimulus(0, 0, -1);
      checkOutput("pr_valid_t2", 32'(obsValidEarly), 32'd0);
      checkOutput("pr_color", 32'(obsColor), 32'h66);
      checkOutput("pr_valid", 32'(obsValid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Per-pixel sprite front/back end around the shared sprite RAM.
- Front end: compares the current VGA pixel against 10 alien boxes and 1 player box, then drives one registered read address per sprite port.
- Back end: takes the RAM's registered read data, applies transparency and priority, and emits one colour index per pixel to the VGA colour stage.
- Also accumulates per-frame player/alien overlap for game logic.

Parameters:
- NUM_ALIENS, 10, number of alien sprite ports (must match the RAM port count).
- DATA_WIDTH, 8, colour index width.
- ADDRESS_WIDTH, 10, sprite RAM address width.
- X_WIDTH, 10, pixel x width.
- Y_WIDTH, 9, pixel y width.
- SPRITE_W, 16, sprite width in pixels (power of 2).
- SPRITE_H, 16, sprite height in pixels (power of 2).
- ALIEN_BASE, 0, RAM base address of the alien image.
- PLAYER_BASE, 256, RAM base address of the player image.
- TRANSPARENT, 8'h00, colour index treated as see-through.
- BG_COLOR, 8'h00, colour output when no opaque sprite is present.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- pixel_x  in  X_WIDTH  current pixel column.
- pixel_y  in  Y_WIDTH  current pixel row.
- pixel_valid  in  1  pixel is in the active video area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- alien_x_flat  in  NUM_ALIENS*X_WIDTH  alien top-left x; alien i at [i*X_WIDTH +: X_WIDTH].
- alien_y_flat  in  NUM_ALIENS*Y_WIDTH  alien top-left y; same packing.
- alien_alive  in  NUM_ALIENS  per-alien enable.
- player_x  in  X_WIDTH  player top-left x.
- player_y  in  Y_WIDTH  player top-left y.
- ram_wr_active  in  1  sprite RAM write enable, mirrored; reads are stale while it is high.
- addr_alien_flat  out  NUM_ALIENS*ADDRESS_WIDTH  registered alien read addresses.
- addr_player  out  ADDRESS_WIDTH  registered player read address.
- alien_data_flat  in  NUM_ALIENS*DATA_WIDTH  RAM read data, alien ports.
- player_data  in  DATA_WIDTH  RAM read data, player port.
- pixel_color  out  DATA_WIDTH  composited colour index.
- color_valid  out  1  pixel_color corresponds to an active pixel.
- collision_report  out  NUM_ALIENS  overlap bits for the previous frame.
- collision_strobe  out  1  one-cycle pulse when collision_report updates.

Behaviour:
- Reset (async assert, sync release): all snapshot, pipeline and output registers clear.
  - addr outputs = their base addresses; pixel_color = BG_COLOR; color_valid = 0; collision_report = 0; collision_strobe = 0.
- Position snapshot:
  - On frame_start, all positions and alien_alive are latched into shadow registers.
  - Compares use only the shadow values, so mid-frame position updates never tear a frame.
  - Shadows reset to 0 with alive = 0.
- Stage 1 (cycle T, pixel presented):
  - A sprite is in its box when pixel_valid is high, it is alive (the player is always alive), sx <= x < sx+SPRITE_W, and sy <= y < sy+SPRITE_H.
  - Compute sx+W and sy+H one bit wider than the operand so the box never wraps at the screen edge.
  - addr = base + (y-sy)*SPRITE_W + (x-sx), with the offsets truncated to log2 of the sprite size.
  - When out of box, drive addr = base.
  - Addresses and in-box flags are registered and visible at T+1.
- Stage 2:
  - The RAM returns data at T+2.
  - In-box flags and pixel_valid are delayed to align with the data.
  - ram_wr_active sampled at T+1 is carried along as a stale flag.
- Stage 3:
  - A sprite is opaque when in-box, not stale, and data != TRANSPARENT.
  - Priority: player first, then alien 0 up to alien NUM_ALIENS-1; the lowest index wins.
  - If no sprite is opaque, output BG_COLOR.
  - pixel_color and color_valid are registered at T+3, so total latency = 3 cycles with throughput of 1 pixel per cycle.
- Collision:
  - When the player and alien i are both opaque at stage 3, set acc[i].
  - On frame_start: collision_report <= acc, collision_strobe = 1 for one cycle, and acc clears.
  - If a hit and frame_start occur in the same cycle, the hit goes into the new (cleared) accumulator.
- pixel_valid low: all flags are false, output is BG_COLOR, and color_valid is low exactly 3 cycles later.
- Reset mid-frame: in-flight pixels are discarded; the first valid output is 3 cycles after the first post-reset valid pixel.

Test Plan:
1. Player shadow at (100,200), data at offset 5*16+3 = 8'h1C; present (103,205) -> addr_player = 256+83 = 339 at T+1; pixel_color = 8'h1C, color_valid = 1 at T+3.
2. Player and alien 2 both opaque at the same pixel (player = 8'h33, alien = 8'h44) -> pixel_color = 8'h33; acc[2] set; next frame_start -> collision_report = 10'b0000000100 with a one-cycle strobe.
3. Alien 0 sprite at x = 1015 (X_WIDTH = 10) -> pixel x = 1014 is outside; x = 1015 is in box with col 0; no wrap-around hit at x = 0..6.
4. Alien 4 at (10,10) with alive = 0, opaque data -> pixel_color = BG_COLOR; addr_alien[4] = ALIEN_BASE.
5. Player opaque pixel with ram_wr_active high exactly at T+1 -> output BG_COLOR; ram_wr_active high at T or T+2 instead -> player colour.
6. Change player_x mid-frame -> output is unchanged until the next frame_start; assert resetn low mid-stream -> outputs are immediately BG_COLOR, color_valid = 0, report = 0.
